rr_warp_arbiter: RTL and testbench

RR_WARP_ARBITER -- requirements
Module: rr_warp_arbiter

---
 rtl/rr_warp_arbiter.sv | 155 +++++++++++++++
 tb/tb_rr_warp_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_warp_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_warp_arbiter: 8-warp round-robin issue arbiter with held grant.       |
// | Optional per-warp acceptance counters under macro ARB_GRANT_CNT_EN.      |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module rr_warp_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       flush,
  input  logic       grant_ready,
  output logic       grant_valid,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic [7:0] mr_req
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [63:0] grant_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_id_q, grant_id_d;
  logic [7:0] mr_req_q, mr_req_d;

  logic        accept;
  logic [7:0]  arb_ptr;
  logic [7:0]  arb_req;
  logic [2:0]  ptr_idx;
  logic [2:0]  start_idx;
  logic [15:0] rot_dbl;
  logic [7:0]  rot_req;
  logic        win_found;
  logic [2:0]  win_off;
  logic [2:0]  win_idx;
  logic [7:0]  win_onehot;

  assign accept = (state_q == ST_HOLD) && grant_ready;

  // On acceptance the pointer advances to the accepted warp and that warp
  // sits out the very next arbitration.
  assign arb_ptr = accept ? grant_q : mr_req_q;
  assign arb_req = accept ? (req & ~grant_q) : req;

  always_comb begin
    ptr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (arb_ptr[i]) ptr_idx = 3'(i);
    end
  end

  assign start_idx = ptr_idx + 3'd1;
  assign rot_dbl   = {arb_req, arb_req} >> start_idx;
  assign rot_req   = rot_dbl[7:0];

  always_comb begin
    win_found = 1'b0;
    win_off   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_found = 1'b1;
        win_off   = 3'(i);
      end
    end
  end

  assign win_idx    = win_off + start_idx;
  assign win_onehot = 8'd1 << win_idx;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    mr_req_d   = mr_req_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d    = ST_HOLD;
          grant_d    = win_onehot;
          grant_id_d = win_idx;
        end
      end
      ST_HOLD: begin
        if (grant_ready) begin
          mr_req_d = grant_q;
          if (win_found) begin
            grant_d    = win_onehot;
            grant_id_d = win_idx;
          end else begin
            state_d    = ST_IDLE;
            grant_d    = 8'd0;
            grant_id_d = 3'd0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = 8'd0;
        grant_id_d = 3'd0;
      end
    endcase
    // Flush drops the pending grant but a same-cycle acceptance still moves the pointer.
    if (flush) begin
      state_d    = ST_IDLE;
      grant_d    = 8'd0;
      grant_id_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 8'd0;
      grant_id_q <= 3'd0;
      mr_req_q   <= 8'b1000_0000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      mr_req_q   <= mr_req_d;
    end
  end

  assign grant_valid = (state_q == ST_HOLD);
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign mr_req      = mr_req_q;

`ifdef ARB_GRANT_CNT_EN
  for (genvar g = 0; g < 8; g++) begin : g_cnt
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && grant_q[g] && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
    end

    assign grant_cnt[8*g +: 8] = cnt_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_warp_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_rr_warp_arbiter: directed self-checking bench for rr_warp_arbiter.    |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_rr_warp_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       flush;
  logic       grant_ready;
  logic       grant_valid;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic [7:0] mr_req;
`ifdef ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  int n_tests;
  int n_fail;

  rr_warp_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .flush       (flush),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant       (grant),
    .grant_id    (grant_id),
    .mr_req      (mr_req)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req         = 8'd0;
    flush       = 1'b0;
    grant_ready = 1'b0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] g,
                           input logic [2:0] id, input logic [7:0] mr);
    check_val({tag, ".valid"}, 64'(grant_valid), 64'(v));
    check_val({tag, ".grant"}, 64'(grant), 64'(g));
    check_val({tag, ".id"}, 64'(grant_id), 64'(id));
    check_val({tag, ".mr"}, 64'(mr_req), 64'(mr));
  endtask

  initial begin
    logic [7:0] exp_g;
    logic [7:0] exp_mr;
    n_tests = 0;
    n_fail  = 0;

    // Reset values
    do_reset();
    check_out("reset", 1'b0, 8'h00, 3'd0, 8'h80);

    // Full request, always ready: 0,1,...,7,0 back to back
    req         = 8'hFF;
    grant_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_g  = 8'd1 << (k % 8);
      exp_mr = (k == 0) ? 8'h80 : (8'd1 << ((k - 1) % 8));
      check_out($sformatf("rr%0d", k), 1'b1, exp_g, 3'(k % 8), exp_mr);
    end
    req = 8'h00;
    step();
    check_out("rr_drain", 1'b0, 8'h00, 3'd0, 8'h01);

    // Stalled grant stays put, even when its request drops
    do_reset();
    req         = 8'b0010_0100;
    grant_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out($sformatf("stall%0d", k), 1'b1, 8'h04, 3'd2, 8'h80);
    end
    req = 8'h00;
    step();
    check_out("stall_drop", 1'b1, 8'h04, 3'd2, 8'h80);
    flush = 1'b1;
    step();
    check_out("flush_noacc", 1'b0, 8'h00, 3'd0, 8'h80);
    flush = 1'b0;

    // Wrap past warp 7 from pointer at warp 5
    do_reset();
    req         = 8'b0010_0000;
    grant_ready = 1'b1;
    step();
    check_out("wrap_pre", 1'b1, 8'h20, 3'd5, 8'h80);
    req = 8'b0001_0001;
    step();
    check_out("wrap", 1'b1, 8'h01, 3'd0, 8'h20);

    // Flush together with acceptance: pointer still moves
    do_reset();
    req         = 8'b0000_1000;
    grant_ready = 1'b0;
    step();
    check_out("hold3", 1'b1, 8'h08, 3'd3, 8'h80);
    flush       = 1'b1;
    grant_ready = 1'b1;
    step();
    check_out("flush_acc", 1'b0, 8'h00, 3'd0, 8'h08);
    flush       = 1'b0;
    grant_ready = 1'b0;
    req         = 8'b1001_1001;
    step();
    check_out("prio_from4", 1'b1, 8'h10, 3'd4, 8'h08);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 3'd0, 8'h80);
    step();
    rst_n = 1'b1;
    req   = 8'h00;

`ifdef ARB_GRANT_CNT_EN
    do_reset();
    req         = 8'b0010_0000;
    grant_ready = 1'b1;
    for (int k = 0; k < 620; k++) step();
    check_val("cnt5_sat", 64'(grant_cnt[47:40]), 64'hFF);
    check_val("cnt_others", grant_cnt & ~64'h0000_FF00_0000_0000, 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("cnt_rst", grant_cnt, 64'h0);
    check_out("cnt_rst_out", 1'b0, 8'h00, 3'd0, 8'h80);
    step();
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
